// File: rtl/wbm_byte_bridge.sv
// Byte-stream to Wishbone B4 pipelined master: host command frames become single
// bus transactions, each answered by a status byte and, for good reads, four data bytes.
module wbm_byte_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RXDATA,
        S_REQ,
        S_WAIT,
        S_TXS,
        S_TXD
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic          r_we;
    logic [3:0]    r_adr;
    logic [31:0]   r_datOut;
    logic [31:0]   r_datIn;
    logic [7:0]    r_status;
    logic [1:0]    r_byteCnt;
    logic [TW-1:0] r_timer;

    logic          w_rxFire;
    logic          w_txFire;
    logic          w_busActive;
    logic          w_timeoutHit;
    logic          w_ackHit;
    logic [7:0]    w_txByte;

    assign rx_ready_o = (r_state == S_IDLE) || (r_state == S_RXDATA);
    assign tx_valid_o = (r_state == S_TXS) || (r_state == S_TXD);
    assign wb_cyc_o   = w_busActive;
    assign wb_stb_o   = (r_state == S_REQ);
    assign wb_we_o    = r_we;
    assign wb_adr_o   = r_adr;
    assign wb_sel_o   = 4'hF;
    assign wb_dat_o   = r_datOut;
    assign tx_data_o  = (r_state == S_TXS) ? r_status : w_txByte;

    assign w_rxFire     = rx_valid_i && rx_ready_o;
    assign w_txFire     = tx_valid_o && tx_ready_i;
    assign w_busActive  = (r_state == S_REQ) || (r_state == S_WAIT);
    // The timer counts the cycle it is in, so the last legal cycle is TIMEOUT-1.
    assign w_timeoutHit = w_busActive && (r_timer == TMO_LAST);
    assign w_ackHit     = (r_state == S_WAIT) && wb_ack_i;

    always_comb begin
        w_txByte = r_datIn[31:24];
        case (r_byteCnt)
            2'd0:    w_txByte = r_datIn[31:24];
            2'd1:    w_txByte = r_datIn[23:16];
            2'd2:    w_txByte = r_datIn[15:8];
            default: w_txByte = r_datIn[7:0];
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rxFire) begin
                    w_stateNext = rx_data_i[7] ? S_RXDATA : S_REQ;
                end
            end
            S_RXDATA: begin
                if (w_rxFire && (r_byteCnt == 2'd3)) begin
                    w_stateNext = S_REQ;
                end
            end
            S_REQ: begin
                if (w_timeoutHit) begin
                    w_stateNext = S_TXS;
                end else if (!wb_stall_i) begin
                    w_stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_timeoutHit || w_ackHit) begin
                    w_stateNext = S_TXS;
                end
            end
            S_TXS: begin
                if (w_txFire) begin
                    w_stateNext = ((r_status == 8'h00) && !r_we) ? S_TXD : S_IDLE;
                end
            end
            S_TXD: begin
                if (w_txFire && (r_byteCnt == 2'd3)) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_adr     <= 4'h0;
            r_datOut  <= 32'h0;
            r_datIn   <= 32'h0;
            r_status  <= 8'h00;
            r_byteCnt <= 2'd0;
            r_timer   <= '0;
        end else begin
            r_state <= w_stateNext;
            case (r_state)
                S_IDLE: begin
                    if (w_rxFire) begin
                        r_we      <= rx_data_i[7];
                        r_adr     <= rx_data_i[3:0];
                        r_byteCnt <= 2'd0;
                    end
                end
                S_RXDATA: begin
                    if (w_rxFire) begin
                        r_datOut  <= {r_datOut[23:0], rx_data_i};
                        r_byteCnt <= r_byteCnt + 2'd1;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (w_timeoutHit) begin
                        r_status <= 8'hEE;
                    end else if (w_ackHit) begin
                        r_status <= 8'h00;
                        r_datIn  <= wb_dat_i;
                    end
                end
                S_TXS: begin
                    if (w_txFire) begin
                        r_byteCnt <= 2'd0;
                    end
                end
                S_TXD: begin
                    if (w_txFire) begin
                        r_byteCnt <= r_byteCnt + 2'd1;
                    end
                end
                default: ;
            endcase

            // Saturating so a stuck bus can never wrap back under the limit.
            if ((w_stateNext == S_REQ) && (r_state != S_REQ)) begin
                r_timer <= '0;
            end else if (w_busActive && (r_timer != TMO_MAX)) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wbm_byte_bridge.sv
// Scoreboard bench for wbm_byte_bridge: a randomised slave model plus expected bus
// and response queues derived from the frame rules, checked by independent monitors.
module tb_wbm_byte_bridge;

    localparam int TMO = 8;

    typedef struct {
        int          stallCycles;
        int          ackDelay;
        bit          noAck;
        logic [31:0] rdata;
    } plan_t;

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] dat;
        int          stbLen;
        int          cycLen;
        int          accCnt;
    } wbExp_t;

    logic        clk;
    logic        rst;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        rxReady;
    logic        txValid;
    logic [7:0]  txData;
    logic        txReady;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  adr;
    logic [3:0]  sel;
    logic [31:0] datO;
    logic [31:0] datI;
    logic        stall;
    logic        ack;

    int          checks = 0;
    int          errors = 0;

    plan_t       planQ[$];
    wbExp_t      wbExpQ[$];
    logic [7:0]  txExpQ[$];

    bit          inCyc = 0;
    bit          holdReq = 0;
    int          holdLeft = 0;

    wbm_byte_bridge #(.TIMEOUT(TMO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .rx_valid_i (rxValid),
        .rx_data_i  (rxData),
        .rx_ready_o (rxReady),
        .tx_valid_o (txValid),
        .tx_data_o  (txData),
        .tx_ready_i (txReady),
        .wb_cyc_o   (cyc),
        .wb_stb_o   (stb),
        .wb_we_o    (we),
        .wb_adr_o   (adr),
        .wb_sel_o   (sel),
        .wb_dat_o   (datO),
        .wb_dat_i   (datI),
        .wb_stall_i (stall),
        .wb_ack_i   (ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Slave model: inputs change 2 time units after the edge, so they are settled by the negedge.
    initial begin
        plan_t cur;
        bit    active;
        bit    accepted;
        int    stallLeft;
        int    waitLeft;
        active = 0;
        accepted = 0;
        stallLeft = 0;
        waitLeft = 0;
        cur = '{0, 0, 1'b1, 32'h0};
        stall = 1'b0;
        ack = 1'b0;
        datI = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            ack = 1'b0;
            datI = $urandom;
            if (rst || !cyc) begin
                active = 0;
                accepted = 0;
                stall = 1'b0;
                ack = ($urandom_range(0, 3) == 0);
            end else begin
                if (!active && stb) begin
                    active = 1;
                    accepted = 0;
                    if (planQ.size() != 0) cur = planQ.pop_front();
                    else cur = '{0, 0, 1'b1, 32'h0};
                    stallLeft = cur.stallCycles;
                end
                if (stb) begin
                    ack = ($urandom_range(0, 3) == 0);
                    if (stallLeft > 0) begin
                        stall = 1'b1;
                        stallLeft--;
                    end else begin
                        stall = 1'b0;
                        accepted = 1;
                        waitLeft = cur.ackDelay;
                    end
                end else if (accepted && !cur.noAck) begin
                    stall = 1'b0;
                    if (waitLeft == 0) begin
                        ack = 1'b1;
                        datI = cur.rdata;
                        accepted = 0;
                    end else begin
                        waitLeft--;
                    end
                end
            end
        end
    end

    // Downstream readiness: mostly random, with an optional 5-cycle stall on the next response.
    initial begin
        txReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (holdReq && txValid) begin
                holdLeft = 5;
                holdReq = 0;
            end
            if (holdLeft > 0) begin
                txReady = 1'b0;
                holdLeft--;
            end else begin
                txReady = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Bus monitor: one expected record per cyc pulse.
    initial begin
        wbExp_t      cur;
        int          cycCnt;
        int          stbCnt;
        int          accCnt;
        bit          stableOk;
        logic [3:0]  firstAdr;
        logic        firstWe;
        logic [31:0] firstDat;
        cycCnt = 0;
        stbCnt = 0;
        accCnt = 0;
        stableOk = 1;
        firstAdr = 4'h0;
        firstWe = 1'b0;
        firstDat = 32'h0;
        cur = '{1'b0, 4'h0, 32'h0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                inCyc = 0;
            end else if (cyc) begin
                if (!inCyc) begin
                    inCyc = 1;
                    cycCnt = 0;
                    stbCnt = 0;
                    accCnt = 0;
                    stableOk = 1;
                    firstAdr = adr;
                    firstWe = we;
                    firstDat = datO;
                    if (wbExpQ.size() == 0) begin
                        checkOutput("wb_unexpected_cycle", 32'(wbExpQ.size()), 1);
                        cur = '{we, adr, datO, 0, 0, 0};
                    end else begin
                        cur = wbExpQ.pop_front();
                        checkOutput("wb_adr", 32'(adr), 32'(cur.adr));
                        checkOutput("wb_we", 32'(we), 32'(cur.we));
                        checkOutput("wb_sel", 32'(sel), 32'hF);
                        if (cur.we) checkOutput("wb_dat", datO, cur.dat);
                    end
                end
                cycCnt++;
                if (stb) begin
                    stbCnt++;
                    if (adr !== firstAdr || we !== firstWe || datO !== firstDat) stableOk = 0;
                    if (!stall) accCnt++;
                end
            end else if (inCyc) begin
                inCyc = 0;
                checkOutput("wb_stable", 32'(stableOk), 1);
                checkOutput("wb_stb_len", 32'(stbCnt), 32'(cur.stbLen));
                checkOutput("wb_cyc_len", 32'(cycCnt), 32'(cur.cycLen));
                checkOutput("wb_accept_cnt", 32'(accCnt), 32'(cur.accCnt));
            end else if (stb) begin
                checkOutput("wb_stb_without_cyc", 32'(stb), 0);
            end
        end
    end

    // Response monitor: pops the expected byte on every tx handshake.
    initial begin
        bit         prevHeld;
        logic [7:0] prevData;
        logic [7:0] expByte;
        prevHeld = 0;
        prevData = 8'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevHeld = 0;
            end else begin
                if (prevHeld) begin
                    checkOutput("tx_valid_held", 32'(txValid), 1);
                    checkOutput("tx_data_held", 32'(txData), 32'(prevData));
                end
                if (txValid) checkOutput("rx_ready_during_tx", 32'(rxReady), 0);
                if (txValid && txReady) begin
                    if (txExpQ.size() == 0) begin
                        checkOutput("tx_unexpected_byte", 32'(txData), 32'h100);
                    end else begin
                        expByte = txExpQ.pop_front();
                        checkOutput("tx_byte", 32'(txData), 32'(expByte));
                    end
                end
                prevHeld = txValid && !txReady;
                prevData = txData;
            end
        end
    end

    task automatic sendByte(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clk);
        #2;
        rxValid = 1'b1;
        rxData = b;
        @(negedge clk);
        while (!rxReady && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rx_accept", 32'(rxReady), 1);
        @(posedge clk);
        #2;
        rxValid = 1'b0;
    endtask

    // Expected outcome from the frame rules: ack index counted from the first strobe cycle.
    task automatic applyStimulus(input bit isWrite, input logic [3:0] a, input logic [2:0] junk,
                                 input logic [31:0] data, input int stallCycles, input int ackDelay,
                                 input bit noAck, input logic [31:0] rdata);
        int     ackIdx;
        bit     ok;
        wbExp_t e;
        plan_t  p;
        ackIdx = stallCycles + 1 + ackDelay;
        ok = !noAck && (ackIdx <= TMO - 2);
        e.we = isWrite;
        e.adr = a;
        e.dat = data;
        e.stbLen = (stallCycles + 1 < TMO) ? stallCycles + 1 : TMO;
        e.accCnt = (stallCycles <= TMO - 1) ? 1 : 0;
        e.cycLen = ok ? ackIdx + 1 : TMO;
        p = '{stallCycles, ackDelay, noAck, rdata};
        planQ.push_back(p);
        wbExpQ.push_back(e);
        txExpQ.push_back(ok ? 8'h00 : 8'hEE);
        if (ok && !isWrite) begin
            for (int k = 3; k >= 0; k--) txExpQ.push_back(8'((rdata >> (8 * k)) & 32'hFF));
        end
        sendByte({isWrite, junk, a});
        if (isWrite) begin
            for (int k = 3; k >= 0; k--) sendByte(8'((data >> (8 * k)) & 32'hFF));
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((txExpQ.size() != 0 || wbExpQ.size() != 0 || inCyc || txValid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) checkOutput("drain_pending", 32'(txExpQ.size() + wbExpQ.size()), 0);
    endtask

    task automatic checkResetState();
        @(negedge clk);
        checkOutput("rst_cyc", 32'(cyc), 0);
        checkOutput("rst_stb", 32'(stb), 0);
        checkOutput("rst_we", 32'(we), 0);
        checkOutput("rst_tx_valid", 32'(txValid), 0);
        checkOutput("rst_adr", 32'(adr), 0);
        checkOutput("rst_dat_o", datO, 0);
        checkOutput("rst_rx_ready", 32'(rxReady), 1);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        rw;
        logic [3:0]  ra;
        logic [2:0]  rj;
        logic [31:0] rd;
        logic [31:0] rr;
        int          rs;
        int          rdl;
        bit          rn;
        rst = 1'b1;
        rxValid = 1'b0;
        rxData = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        checkResetState();

        applyStimulus(1'b1, 4'h3, 3'b000, 32'h11223344, 0, 0, 1'b0, 32'h0);
        applyStimulus(1'b0, 4'h5, 3'b000, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF);
        applyStimulus(1'b1, 4'hA, 3'b101, 32'hCAFEF00D, 3, 0, 1'b0, 32'h0);
        applyStimulus(1'b0, 4'h7, 3'b010, 32'h0, 0, 0, 1'b1, 32'h12345678);
        applyStimulus(1'b0, 4'h2, 3'b000, 32'h0, 3, 3, 1'b0, 32'hA5A5A5A5);
        applyStimulus(1'b0, 4'h2, 3'b111, 32'h0, 3, 2, 1'b0, 32'h0F1E2D3C);
        applyStimulus(1'b1, 4'hF, 3'b111, 32'h01020304, 9, 0, 1'b0, 32'h0);
        waitIdle();

        holdReq = 1;
        applyStimulus(1'b0, 4'h4, 3'b000, 32'h0, 1, 1, 1'b0, 32'h89ABCDEF);
        waitIdle();

        sendByte(8'h8A);
        sendByte(8'h55);
        sendByte(8'h66);
        pulseReset();
        checkResetState();
        applyStimulus(1'b0, 4'h9, 3'b000, 32'h0, 0, 1, 1'b0, 32'h13579BDF);
        waitIdle();

        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 4'($urandom_range(0, 15));
            rj = 3'($urandom_range(0, 7));
            rd = $urandom;
            rr = $urandom;
            rs = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
            rdl = $urandom_range(0, 3);
            rn = ($urandom_range(0, 7) == 0);
            applyStimulus(rw, ra, rj, rd, rs, rdl, rn, rr);
        end
        waitIdle();

        checkOutput("tx_queue_empty", 32'(txExpQ.size()), 0);
        checkOutput("wb_queue_empty", 32'(wbExpQ.size()), 0);
        checkOutput("plan_queue_empty", 32'(planQ.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
